// File: rtl/irq_ctrl_pkg.sv
// Shared constants for the interrupt controller: register map and FSM encoding.
package irq_ctrl_pkg;

  localparam logic [1:0] ADDR_PEND = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd1;
  localparam logic [1:0] ADDR_EDGE = 2'd2;
  localparam logic [1:0] ADDR_ID   = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

endpackage

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: lowest set index wins.
module irq_prio_enc #(
  parameter int N    = 8,
  parameter int ID_W = 4
) (
  input  logic [N-1:0]    req,
  output logic [ID_W-1:0] id,
  output logic            valid
);

  always_comb begin
    id    = '0;
    valid = 1'b0;
    // Scan downwards so the lowest asserted index is the last one written.
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        id    = ID_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Non-nesting interrupt controller feeding a CP0 interrupt input.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int N_SRC = 8,
  parameter int ID_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_SRC-1:0]  src,
  input  logic              reg_we,
  input  logic [1:0]        reg_addr,
  input  logic [31:0]       reg_wdata,
  output logic [31:0]       reg_rdata,
  output logic              ir_out,
  input  logic              ir_ack,
  input  logic              eret
);

  logic [N_SRC-1:0] sync1, s, s_d;
  logic [N_SRC-1:0] pend, mask, edge_mode;
  logic [N_SRC-1:0] active, rise, clr, pend_next;
  logic [ID_W-1:0]  cand_id, id;
  logic             cand_vld, ack_take;
  state_t           state;
  logic             unused_wdata;

  assign unused_wdata = ^reg_wdata;

  assign active = pend & mask;

  irq_prio_enc #(.N(N_SRC), .ID_W(ID_W)) u_prio_enc (
    .req   (active),
    .id    (cand_id),
    .valid (cand_vld)
  );

  assign ack_take = (state == ST_REQ) && ir_ack && cand_vld;

  // Edge bits: a fresh rising edge beats any clear landing in the same cycle.
  always_comb begin
    rise = s & ~s_d;
    clr  = '0;
    if (reg_we && reg_addr == ADDR_PEND)
      clr = reg_wdata[N_SRC-1:0];
    if (ack_take)
      clr = clr | (N_SRC'(1) << cand_id);
    pend_next = (edge_mode & (rise | (pend & ~clr))) | (~edge_mode & s);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1     <= '0;
      s         <= '0;
      s_d       <= '0;
      pend      <= '0;
      mask      <= '0;
      edge_mode <= '0;
    end else begin
      sync1 <= src;
      s     <= sync1;
      s_d   <= s;
      pend  <= pend_next;
      if (reg_we && reg_addr == ADDR_MASK)
        mask <= reg_wdata[N_SRC-1:0];
      if (reg_we && reg_addr == ADDR_EDGE)
        edge_mode <= reg_wdata[N_SRC-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      ir_out <= 1'b0;
      id     <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (|active) begin
            state  <= ST_REQ;
            ir_out <= 1'b1;
          end
        end
        ST_REQ: begin
          if (ack_take) begin
            state  <= ST_SERVICE;
            ir_out <= 1'b0;
            id     <= cand_id;
          end else if (!(|active)) begin
            state  <= ST_IDLE;
            ir_out <= 1'b0;
          end
        end
        ST_SERVICE: begin
          ir_out <= 1'b0;
          if (eret)
            state <= ST_IDLE;
        end
        default: begin
          state  <= ST_IDLE;
          ir_out <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    reg_rdata = '0;
    unique case (reg_addr)
      ADDR_PEND: reg_rdata = 32'(pend);
      ADDR_MASK: reg_rdata = 32'(mask);
      ADDR_EDGE: reg_rdata = 32'(edge_mode);
      ADDR_ID: begin
        if (state == ST_SERVICE) begin
          reg_rdata     = 32'(id);
          reg_rdata[31] = 1'b1;
        end
      end
      default: reg_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Randomized and directed bench for irq_ctrl against a cycle-level behavioural model.
module tb_irq_ctrl;

  localparam int N = 8;
  localparam logic [15:0] NMASK = 16'h00FF;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [N-1:0] src = '0;
  logic        reg_we = 1'b0;
  logic [1:0]  reg_addr = 2'd0;
  logic [31:0] reg_wdata = '0;
  logic [31:0] reg_rdata;
  logic        ir_out;
  logic        ir_ack = 1'b0;
  logic        eret = 1'b0;

  int n_chk = 0;
  int n_fail = 0;

  irq_ctrl #(.N_SRC(N), .ID_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .src       (src),
    .reg_we    (reg_we),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_rdata (reg_rdata),
    .ir_out    (ir_out),
    .ir_ack    (ir_ack),
    .eret      (eret)
  );

  always #5 clk = ~clk;

  // Reference model: src history, register contents, phase 0=idle 1=request 2=service
  logic [15:0] m_s1, m_s2, m_sp, m_pend, m_mask, m_edge;
  int          m_phase, m_id;
  logic        m_irq;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int lowest(input logic [15:0] v);
    for (int i = 0; i < N; i++)
      if (v[i]) return i;
    return -1;
  endfunction

  function automatic logic [31:0] m_read(input logic [1:0] a);
    case (a)
      2'd0: return {16'h0, m_pend};
      2'd1: return {16'h0, m_mask};
      2'd2: return {16'h0, m_edge};
      default: return (m_phase == 2) ? (32'h8000_0000 | m_id) : 32'h0;
    endcase
  endfunction

  task automatic m_reset();
    m_s1 = '0; m_s2 = '0; m_sp = '0;
    m_pend = '0; m_mask = '0; m_edge = '0;
    m_phase = 0; m_id = 0; m_irq = 1'b0;
  endtask

  task automatic m_step();
    logic [15:0] s, rise, act, clr, np;
    int c;
    bit take;
    s    = m_s2;
    rise = s & ~m_sp;
    act  = m_pend & m_mask;
    c    = lowest(act);
    clr  = (reg_we && reg_addr == 2'd0) ? reg_wdata[15:0] & NMASK : 16'h0;
    take = (m_phase == 1) && ir_ack && (c >= 0);
    if (take) clr[c] = 1'b1;
    np = '0;
    for (int i = 0; i < N; i++)
      np[i] = m_edge[i] ? (rise[i] || (m_pend[i] && !clr[i])) : s[i];
    if (m_phase == 0) begin
      if (act != 0) m_phase = 1;
    end else if (m_phase == 1) begin
      if (take) begin m_phase = 2; m_id = c; end
      else if (act == 0) m_phase = 0;
    end else if (eret) begin
      m_phase = 0;
    end
    m_irq = (m_phase == 1);
    if (reg_we && reg_addr == 2'd1) m_mask = reg_wdata[15:0] & NMASK;
    if (reg_we && reg_addr == 2'd2) m_edge = reg_wdata[15:0] & NMASK;
    m_pend = np;
    m_sp = m_s2; m_s2 = m_s1; m_s1 = {8'h0, src};
  endtask

  task automatic tick();
    m_step();
    @(posedge clk);
    #1;
    chk("ir_out", {31'h0, ir_out}, {31'h0, m_irq});
    chk("rdata", reg_rdata, m_read(reg_addr));
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    reg_we = 1'b1; reg_addr = a; reg_wdata = d;
    tick();
    reg_we = 1'b0; reg_wdata = '0;
  endtask

  task automatic rd(input string tag, input logic [1:0] a, input logic [31:0] exp);
    reg_addr = a;
    #1;
    chk(tag, reg_rdata, exp);
  endtask

  task automatic wait_irq(input string tag, input bit lvl, input int bound);
    for (int k = 0; k < bound && ir_out !== lvl; k++) tick();
    chk(tag, {31'h0, ir_out}, {31'h0, lvl});
  endtask

  task automatic pulse_src(input logic [N-1:0] bits);
    src = src | bits; tick(); tick();
    src = src & ~bits;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    m_reset();
    #1;
    chk("rst_irq", {31'h0, ir_out}, 32'h0);
    for (int a = 0; a < 4; a++) rd("rst_reg", 2'(a), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    m_reset();
    @(posedge clk); #1;
    do_reset();

    // Edge source 0: request, acknowledge, return.
    wr(2'd1, 32'h01); wr(2'd2, 32'h01);
    pulse_src(8'h01);
    wait_irq("s033_irq", 1'b1, 6);
    ir_ack = 1'b1; tick(); ir_ack = 1'b0;
    rd("s033_id", 2'd3, 32'h8000_0000);
    rd("s033_pend", 2'd0, 32'h0);
    eret = 1'b1; tick(); eret = 1'b0;
    rd("s033_idle", 2'd3, 32'h0);

    // Two simultaneous edges: lower index served first, then the other.
    do_reset();
    wr(2'd1, 32'h0C); wr(2'd2, 32'h0C);
    pulse_src(8'h0C);
    wait_irq("s034_irq1", 1'b1, 6);
    ir_ack = 1'b1; tick(); ir_ack = 1'b0;
    rd("s034_id2", 2'd3, 32'h8000_0002);
    eret = 1'b1; tick(); eret = 1'b0;
    wait_irq("s034_irq2", 1'b1, 4);
    ir_ack = 1'b1; tick(); ir_ack = 1'b0;
    rd("s034_id3", 2'd3, 32'h8000_0003);
    eret = 1'b1; tick(); eret = 1'b0;

    // Level source withdrawn before acknowledge.
    do_reset();
    wr(2'd1, 32'h02);
    src[1] = 1'b1;
    wait_irq("s035_irq", 1'b1, 6);
    src[1] = 1'b0;
    wait_irq("s035_drop", 1'b0, 6);
    tick();
    rd("s035_id", 2'd3, 32'h0);
    rd("s035_pend", 2'd0, 32'h0);

    // New edge during service is held pending, then requested after eret.
    do_reset();
    wr(2'd1, 32'h01); wr(2'd2, 32'h01);
    pulse_src(8'h01);
    wait_irq("s036_irq", 1'b1, 6);
    ir_ack = 1'b1; tick(); ir_ack = 1'b0;
    tick(); tick();
    pulse_src(8'h01);
    for (int k = 0; k < 4; k++) tick();
    chk("s036_noirq", {31'h0, ir_out}, 32'h0);
    rd("s036_pend", 2'd0, 32'h01);
    eret = 1'b1; tick(); eret = 1'b0;
    wait_irq("s036_irq2", 1'b1, 3);

    // W1C colliding with a new edge: the set wins; a lone W1C clears.
    do_reset();
    wr(2'd2, 32'h20);
    pulse_src(8'h20);
    for (int k = 0; k < 3; k++) tick();
    rd("s037_set", 2'd0, 32'h20);
    src[5] = 1'b1; tick(); tick();
    wr(2'd0, 32'h20);
    rd("s037_race", 2'd0, 32'h20);
    src[5] = 1'b0; tick();
    wr(2'd0, 32'h20);
    rd("s037_clr", 2'd0, 32'h0);

    // Reset while a request is outstanding.
    wr(2'd1, 32'hFF); wr(2'd2, 32'hFF);
    pulse_src(8'h10);
    wait_irq("s038_irq", 1'b1, 6);
    do_reset();

    // Random traffic.
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if ($urandom_range(0, 3) == 0) src = src ^ N'(1 << $urandom_range(0, N - 1));
      reg_we    = ($urandom_range(0, 9) == 0);
      reg_addr  = 2'($urandom_range(0, 3));
      reg_wdata = $urandom;
      ir_ack    = ($urandom_range(0, 5) == 0);
      eret      = ($urandom_range(0, 5) == 0);
      tick();
    end
    reg_we = 1'b0; ir_ack = 1'b0; eret = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
